fuzz_round_ctrl: RTL and testbench

//  Sequences one differential fuzzing round for the base/variant TestHarness pair: holds both DUTs in reset,

---
 rtl/fuzz_round_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_fuzz_round_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_round_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : fuzz_round_ctrl
// Description : Sequences one differential fuzzing round for a base/variant
//               harness pair. The round runs through these states:
//               - reset: hold both DUTs in reset
//               - run: let both DUTs execute
//               - exit: detect pass (tohost[0]) or cycle timeout
//               - halt: freeze the harness clocks
//               - report: hand the result to the host over valid/ready
//               - reload: optionally request a memory reload and loop
//               While running, a stall/watchdog interrupt (msip kick) is raised
//               when coverage stops moving or no pass arrives in time.
// Ports       :
//   i_clock        clock
//   i_reset_n      asynchronous active-low reset
//   i_start        begin a round (sampled in IDLE only)
//   i_fuzz         1: loop through RELOAD after report, 0: back to IDLE
//   i_max_cycles   RUN cycle limit, 0 disables the timeout
//   i_tohost       tohost value from the harness, bit0 = pass
//   i_cov          coverage sum from the DUT
//   o_dut_reset    active-high reset to both harnesses
//   o_clock_en     clock enable to both harnesses
//   o_interrupt    stall / watchdog interrupt
//   o_done_valid   result available
//   i_done_ready   host accepts result
//   o_done_status  2'b01 PASS, 2'b10 TIMEOUT
//   o_done_cycles  RUN cycles consumed, including the exit cycle
//   o_done_tohost  tohost captured at exit (0 on TIMEOUT)
//   o_reload_req   memory / cosim reload request
//   i_reload_ack   reload complete
//   o_busy         controller not idle
// Revision    : 1.0 - initial release
//==============================================================================
module fuzz_round_ctrl #(
  parameter int unsigned MAX_WAIT_CYCLE = 1000,
  parameter int unsigned WATCHDOG_LIMIT = 50000,
  parameter int unsigned RESET_CYCLES   = 8,
  parameter int unsigned HALT_CYCLES    = 5,
  parameter int unsigned COV_W          = 30,
  parameter int unsigned COV_SHIFT      = 19
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_fuzz,
  input  logic [63:0]      i_max_cycles,
  input  logic [63:0]      i_tohost,
  input  logic [COV_W-1:0] i_cov,
  output logic             o_dut_reset,
  output logic             o_clock_en,
  output logic             o_interrupt,
  output logic             o_done_valid,
  input  logic             i_done_ready,
  output logic [1:0]       o_done_status,
  output logic [63:0]      o_done_cycles,
  output logic [63:0]      o_done_tohost,
  output logic             o_reload_req,
  input  logic             i_reload_ack,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_RUN    = 3'd2,
    S_HALT   = 3'd3,
    S_REPORT = 3'd4,
    S_RELOAD = 3'd5
  } state_t;

  localparam logic [31:0] c_RST_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] c_HALT_LAST = 32'(HALT_CYCLES - 1);
  localparam logic [63:0] c_WD_LIMIT  = 64'(WATCHDOG_LIMIT);
  localparam logic [63:0] c_MAX_WAIT  = 64'(MAX_WAIT_CYCLE);
  localparam logic [1:0]  c_ST_PASS   = 2'b01;
  localparam logic [1:0]  c_ST_TMO    = 2'b10;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_phase_cnt;
  logic [31:0]        w_phase_nxt;
  logic [63:0]        r_cycle_cnt;
  logic [63:0]        w_cycle_nxt;
  logic [63:0]        r_stall_cnt;
  logic [63:0]        w_stall_nxt;
  logic [63:0]        r_wd_cnt;
  logic [63:0]        w_wd_nxt;
  logic [COV_W-1:0]   r_pre_cov;
  logic [COV_W-1:0]   w_pre_cov_nxt;

  logic               r_dut_reset;
  logic               r_clock_en;
  logic               r_interrupt;
  logic               r_done_valid;
  logic [1:0]         r_done_status;
  logic [63:0]        r_done_cycles;
  logic [63:0]        r_done_tohost;
  logic               r_reload_req;
  logic               r_busy;

  logic [63:0]        w_cyc_inc;
  logic               w_pass;
  logic               w_tmo;
  logic               w_exit;
  logic               w_int_nxt;
  logic [63:0]        w_tier;
  logic [63:0]        w_thresh;

  // Saturating post-increment value; exit decisions use this so the exit
  // cycle itself is counted.
  assign w_cyc_inc = (r_cycle_cnt == '1) ? r_cycle_cnt : r_cycle_cnt + 64'd1;
  assign w_pass    = i_tohost[0];
  assign w_tmo     = (i_max_cycles != 64'd0) && (w_cyc_inc > i_max_cycles);
  assign w_exit    = (r_state == S_RUN) && (w_pass || w_tmo);

  // Higher coverage tiers get proportionally longer stall budgets.
  assign w_tier    = 64'(i_cov >> COV_SHIFT) + 64'd1;
  assign w_thresh  = c_MAX_WAIT * w_tier;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_RST;
      end
      S_RST: begin
        if (r_phase_cnt == c_RST_LAST) w_state_nxt = S_RUN;
        else                           w_phase_nxt = r_phase_cnt + 32'd1;
      end
      S_RUN: begin
        if (w_pass || w_tmo) w_state_nxt = S_HALT;
      end
      S_HALT: begin
        if (r_phase_cnt == c_HALT_LAST) w_state_nxt = S_REPORT;
        else                            w_phase_nxt = r_phase_cnt + 32'd1;
      end
      S_REPORT: begin
        if (r_done_valid && i_done_ready)
          w_state_nxt = i_fuzz ? S_RELOAD : S_IDLE;
      end
      S_RELOAD: begin
        // The request must already be visible before an ack is accepted.
        if (r_reload_req && i_reload_ack) w_state_nxt = S_RST;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Round counters
  always_comb begin
    w_cycle_nxt   = r_cycle_cnt;
    w_stall_nxt   = r_stall_cnt;
    w_wd_nxt      = r_wd_cnt;
    w_pre_cov_nxt = r_pre_cov;
    if (r_state == S_RST) begin
      w_cycle_nxt   = 64'd0;
      w_stall_nxt   = 64'd0;
      w_wd_nxt      = 64'd0;
      w_pre_cov_nxt = '0;
    end else if (r_state == S_RUN) begin
      w_cycle_nxt = w_cyc_inc;
      if (i_cov != r_pre_cov) begin
        w_pre_cov_nxt = i_cov;
        w_stall_nxt   = 64'd0;
      end else begin
        w_stall_nxt = (r_stall_cnt == '1) ? r_stall_cnt : r_stall_cnt + 64'd1;
      end
      w_wd_nxt = (r_wd_cnt == '1) ? r_wd_cnt : r_wd_cnt + 64'd1;
      // A pass proves forward progress, so both stall measures restart.
      if (w_pass) begin
        w_stall_nxt = 64'd0;
        w_wd_nxt    = 64'd0;
      end
    end
  end

  // Evaluated on the counter values the next cycle will hold, so the
  // registered interrupt lines up with the counters it reflects.
  assign w_int_nxt = (w_state_nxt == S_RUN) &&
                     ((w_stall_nxt >= w_thresh) || (w_wd_nxt >= c_WD_LIMIT));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= 32'd0;
      r_cycle_cnt <= 64'd0;
      r_stall_cnt <= 64'd0;
      r_wd_cnt    <= 64'd0;
      r_pre_cov   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase_cnt <= w_phase_nxt;
      r_cycle_cnt <= w_cycle_nxt;
      r_stall_cnt <= w_stall_nxt;
      r_wd_cnt    <= w_wd_nxt;
      r_pre_cov   <= w_pre_cov_nxt;
    end
  end

  // Outputs are registered from the next state, so they change on the same
  // edge that enters a state.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dut_reset   <= 1'b1;
      r_clock_en    <= 1'b1;
      r_interrupt   <= 1'b0;
      r_done_valid  <= 1'b0;
      r_done_status <= 2'b00;
      r_done_cycles <= 64'd0;
      r_done_tohost <= 64'd0;
      r_reload_req  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_dut_reset  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RST) ||
                      (w_state_nxt == S_RELOAD);
      r_clock_en   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RST) ||
                      (w_state_nxt == S_RUN);
      r_interrupt  <= w_int_nxt;
      r_done_valid <= (w_state_nxt == S_REPORT);
      r_reload_req <= (w_state_nxt == S_RELOAD);
      r_busy       <= (w_state_nxt != S_IDLE);
      // Result fields hold until the next exit; pass has priority over timeout.
      if (w_exit) begin
        r_done_status <= w_pass ? c_ST_PASS : c_ST_TMO;
        r_done_cycles <= w_cyc_inc;
        r_done_tohost <= w_pass ? i_tohost : 64'd0;
      end
    end
  end

  assign o_dut_reset   = r_dut_reset;
  assign o_clock_en    = r_clock_en;
  assign o_interrupt   = r_interrupt;
  assign o_done_valid  = r_done_valid;
  assign o_done_status = r_done_status;
  assign o_done_cycles = r_done_cycles;
  assign o_done_tohost = r_done_tohost;
  assign o_reload_req  = r_reload_req;
  assign o_busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fuzz_round_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_fuzz_round_ctrl
// Description : Directed self-checking bench for fuzz_round_ctrl. Expected
//               values are hand-derived round timings (reset length, exit
//               cycle, halt length, stall/watchdog thresholds).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fuzz_round_ctrl;

  localparam int unsigned COV_W = 30;

  logic             r_clk = 1'b0;
  logic             r_rst_n;
  logic             r_start;
  logic             r_fuzz;
  logic [63:0]      r_max_cycles;
  logic [63:0]      r_tohost;
  logic [COV_W-1:0] r_cov;
  logic             r_done_ready;
  logic             r_reload_ack;

  logic             w_dut_reset;
  logic             w_clock_en;
  logic             w_interrupt;
  logic             w_done_valid;
  logic [1:0]       w_done_status;
  logic [63:0]      w_done_cycles;
  logic [63:0]      w_done_tohost;
  logic             w_reload_req;
  logic             w_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Watchdog shortened so the absolute-limit path is reachable quickly.
  fuzz_round_ctrl #(
    .MAX_WAIT_CYCLE (1000),
    .WATCHDOG_LIMIT (3000),
    .RESET_CYCLES   (8),
    .HALT_CYCLES    (5),
    .COV_W          (COV_W),
    .COV_SHIFT      (19)
  ) u_dut (
    .i_clock       (r_clk),
    .i_reset_n     (r_rst_n),
    .i_start       (r_start),
    .i_fuzz        (r_fuzz),
    .i_max_cycles  (r_max_cycles),
    .i_tohost      (r_tohost),
    .i_cov         (r_cov),
    .o_dut_reset   (w_dut_reset),
    .o_clock_en    (w_clock_en),
    .o_interrupt   (w_interrupt),
    .o_done_valid  (w_done_valid),
    .i_done_ready  (r_done_ready),
    .o_done_status (w_done_status),
    .o_done_cycles (w_done_cycles),
    .o_done_tohost (w_done_tohost),
    .o_reload_req  (w_reload_req),
    .i_reload_ack  (r_reload_ack),
    .o_busy        (w_busy)
  );

  always #5 r_clk = ~r_clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start from IDLE and return at the first RUN negedge, reporting how
  // many negedges saw dut_reset high.
  task automatic start_round(output int rst_cycles);
    int guard;
    r_start = 1'b1;
    @(negedge r_clk);
    r_start = 1'b0;
    rst_cycles = 0;
    guard = 0;
    while (w_dut_reset && guard < 100) begin
      rst_cycles++;
      guard++;
      @(negedge r_clk);
    end
  endtask

  // Wait for done_valid, counting negedges with the clock frozen beforehand.
  task automatic wait_report(output int halt_lo);
    int guard;
    halt_lo = 0;
    guard = 0;
    while (!w_done_valid && guard < 5000) begin
      if (!w_clock_en) halt_lo++;
      guard++;
      @(negedge r_clk);
    end
    check_val("valid_seen", 64'(w_done_valid), 64'd1);
  endtask

  task automatic handshake(input logic fuzz_val);
    r_done_ready = 1'b1;
    r_fuzz       = fuzz_val;
    @(negedge r_clk);
    r_done_ready = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    r_rst_n      = 1'b0;
    r_start      = 1'b0;
    r_fuzz       = 1'b0;
    r_max_cycles = 64'd0;
    r_tohost     = 64'd0;
    r_cov        = '0;
    r_done_ready = 1'b0;
    r_reload_ack = 1'b0;
    repeat (3) @(negedge r_clk);

    // Reset state
    check_val("rst_dut_reset", 64'(w_dut_reset), 64'd1);
    check_val("rst_clock_en", 64'(w_clock_en), 64'd1);
    check_val("rst_interrupt", 64'(w_interrupt), 64'd0);
    check_val("rst_done_valid", 64'(w_done_valid), 64'd0);
    check_val("rst_reload_req", 64'(w_reload_req), 64'd0);
    check_val("rst_busy", 64'(w_busy), 64'd0);
    check_val("rst_done_cycles", w_done_cycles, 64'd0);
    r_rst_n = 1'b1;
    @(negedge r_clk);

    // 1: pass at RUN cycle 100
    start_round(n);
    check_val("t1_rst_len", 64'(n), 64'd8);
    check_val("t1_run_clk_en", 64'(w_clock_en), 64'd1);
    repeat (99) @(negedge r_clk);
    check_val("t1_no_int", 64'(w_interrupt), 64'd0);
    r_tohost = 64'd1;
    wait_report(n);
    r_tohost = 64'd0;
    check_val("t1_halt_len", 64'(n), 64'd5);
    check_val("t1_status", 64'(w_done_status), 64'd1);
    check_val("t1_cycles", w_done_cycles, 64'd100);
    check_val("t1_tohost", w_done_tohost, 64'd1);
    check_val("t1_rep_clk_en", 64'(w_clock_en), 64'd0);
    handshake(1'b0);
    check_val("t1_idle_busy", 64'(w_busy), 64'd0);
    check_val("t1_idle_valid", 64'(w_done_valid), 64'd0);
    check_val("t1_idle_dut_rst", 64'(w_dut_reset), 64'd1);
    check_val("t1_idle_clk_en", 64'(w_clock_en), 64'd1);
    check_val("t1_cycles_kept", w_done_cycles, 64'd100);

    // 2: timeout at 51, tohost bit0 clear
    r_max_cycles = 64'd50;
    r_tohost     = 64'h2;
    start_round(n);
    wait_report(n);
    check_val("t2_halt_len", 64'(n), 64'd5);
    check_val("t2_status", 64'(w_done_status), 64'd2);
    check_val("t2_cycles", w_done_cycles, 64'd51);
    check_val("t2_tohost", w_done_tohost, 64'd0);
    handshake(1'b0);
    r_max_cycles = 64'd0;
    r_tohost     = 64'd0;

    // 3a: cov held at 0, tier 0 -> stall budget 1000
    r_cov = '0;
    start_round(n);
    repeat (999) @(negedge r_clk);
    check_val("t3_int_999", 64'(w_interrupt), 64'd0);
    @(negedge r_clk);
    check_val("t3_int_1000", 64'(w_interrupt), 64'd1);
    r_cov = 30'd5;
    @(negedge r_clk);
    check_val("t3_int_cleared", 64'(w_interrupt), 64'd0);
    r_tohost = 64'd1;
    wait_report(n);
    r_tohost = 64'd0;
    check_val("t3_int_report", 64'(w_interrupt), 64'd0);
    handshake(1'b0);

    // 3b: tier 1 -> stall budget 2000; first RUN cycle sees a cov change
    r_cov = 30'h80000;
    start_round(n);
    repeat (2000) @(negedge r_clk);
    check_val("t3_t1_int_2000", 64'(w_interrupt), 64'd0);
    @(negedge r_clk);
    check_val("t3_t1_int_2001", 64'(w_interrupt), 64'd1);
    r_cov = 30'h80001;
    @(negedge r_clk);
    check_val("t3_t1_cleared", 64'(w_interrupt), 64'd0);
    // watchdog reaches 3000 on RUN cycle 3000 although coverage is fresh
    repeat (997) @(negedge r_clk);
    check_val("t3_wd_2999", 64'(w_interrupt), 64'd0);
    @(negedge r_clk);
    check_val("t3_wd_3000", 64'(w_interrupt), 64'd1);
    r_tohost = 64'd1;
    @(negedge r_clk);
    check_val("t3_int_halt", 64'(w_interrupt), 64'd0);
    wait_report(n);
    r_tohost = 64'd0;
    handshake(1'b0);
    r_cov = '0;

    // 4: pass and timeout together -> PASS; late ready; reload loop
    r_max_cycles = 64'd10;
    r_fuzz       = 1'b1;
    start_round(n);
    repeat (10) @(negedge r_clk);
    r_tohost = 64'd1;
    wait_report(n);
    r_tohost = 64'd0;
    check_val("t4_status", 64'(w_done_status), 64'd1);
    check_val("t4_cycles", w_done_cycles, 64'd11);
    r_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge r_clk);
      check_val("t4_valid_hold", 64'(w_done_valid), 64'd1);
      check_val("t4_status_hold", 64'(w_done_status), 64'd1);
    end
    r_start      = 1'b0;
    r_max_cycles = 64'd0;
    r_reload_ack = 1'b1;   // present on the entry edge; must be ignored
    handshake(1'b1);
    check_val("t4_valid_drop", 64'(w_done_valid), 64'd0);
    check_val("t4_reload_req", 64'(w_reload_req), 64'd1);
    check_val("t4_reload_dut_rst", 64'(w_dut_reset), 64'd1);
    check_val("t4_reload_clk_en", 64'(w_clock_en), 64'd0);
    r_reload_ack = 1'b0;
    r_start      = 1'b1;
    repeat (2) @(negedge r_clk);
    r_start = 1'b0;
    check_val("t4_reload_wait", 64'(w_reload_req), 64'd1);
    r_reload_ack = 1'b1;
    @(negedge r_clk);
    r_reload_ack = 1'b0;
    check_val("t4_req_drop", 64'(w_reload_req), 64'd0);
    check_val("t4_rst_clk_en", 64'(w_clock_en), 64'd1);
    n = 0;
    while (w_dut_reset && n < 100) begin
      n++;
      @(negedge r_clk);
    end
    check_val("t4_rst_len", 64'(n), 64'd8);

    // 6: start pulsed during RUN has no effect
    r_start = 1'b1;
    repeat (3) @(negedge r_clk);
    r_start = 1'b0;
    check_val("t6_run_dut_rst", 64'(w_dut_reset), 64'd0);
    check_val("t6_run_busy", 64'(w_busy), 64'd1);

    // 5a: asynchronous reset during RUN
    #2 r_rst_n = 1'b0;
    #1;
    check_val("t5_run_dut_rst", 64'(w_dut_reset), 64'd1);
    check_val("t5_run_busy", 64'(w_busy), 64'd0);
    check_val("t5_run_valid", 64'(w_done_valid), 64'd0);
    check_val("t5_run_reload", 64'(w_reload_req), 64'd0);
    @(negedge r_clk);
    r_rst_n = 1'b1;
    r_fuzz  = 1'b0;

    // counters restart from zero after reset: timeout at 4
    r_max_cycles = 64'd3;
    start_round(n);
    check_val("t5_rst_len", 64'(n), 64'd8);
    wait_report(n);
    check_val("t5_status", 64'(w_done_status), 64'd2);
    check_val("t5_cycles", w_done_cycles, 64'd4);

    // 5b: asynchronous reset during REPORT
    #2 r_rst_n = 1'b0;
    #1;
    check_val("t5_rep_valid", 64'(w_done_valid), 64'd0);
    check_val("t5_rep_busy", 64'(w_busy), 64'd0);
    check_val("t5_rep_dut_rst", 64'(w_dut_reset), 64'd1);
    check_val("t5_rep_status", 64'(w_done_status), 64'd0);
    @(negedge r_clk);
    r_rst_n = 1'b1;
    @(negedge r_clk);
    @(negedge r_clk);
    check_val("t5_after_busy", 64'(w_busy), 64'd0);
    check_val("t5_after_reload", 64'(w_reload_req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
